sap_datapath: RTL and testbench

SAP_DATAPATH -- requirements
Module: sap_datapath

---
 rtl/sap_datapath.sv | 100 ++++++++++
 tb/tb_sap_datapath.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sap_datapath.sv
// SAP-1 style 8-bit datapath: shared W-bus, PC/MAR/IR/ACC/B/OUT registers,
// 16x8 program RAM and an add/subtract ALU, driven by a 12-bit control word.
module sap_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] con,
  input  logic        prog_en,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  output logic [3:0]  opcode,
  output logic [7:0]  out_reg,
  output logic [7:0]  wbus,
  output logic        bus_conflict
);

  logic [3:0] r_pc;
  logic [3:0] r_mar;
  logic [7:0] r_ir;
  logic [7:0] r_acc;
  logic [7:0] r_b;
  logic [7:0] r_out;
  logic [7:0] r_ram [16];

  // Control word decode; _n fields are inverted here so every w_ strobe is active-high.
  logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo;
  assign w_cp = con[11];
  assign w_ep = con[10];
  assign w_lm = ~con[9];
  assign w_ce = ~con[8];
  assign w_li = ~con[7];
  assign w_ei = ~con[6];
  assign w_la = ~con[5];
  assign w_ea = con[4];
  assign w_su = con[3];
  assign w_eu = con[2];
  assign w_lb = ~con[1];
  assign w_lo = ~con[0];

  logic [7:0] w_alu;
  assign w_alu = w_su ? (r_acc + ~r_b + 8'd1) : (r_acc + r_b);

  // Programming mode parks the bus: every driver is gated off.
  logic w_d_ep, w_d_ce, w_d_ei, w_d_ea, w_d_eu;
  assign w_d_ep = w_ep & ~prog_en;
  assign w_d_ce = w_ce & ~prog_en;
  assign w_d_ei = w_ei & ~prog_en;
  assign w_d_ea = w_ea & ~prog_en;
  assign w_d_eu = w_eu & ~prog_en;

  logic [2:0] w_drv_cnt;
  assign w_drv_cnt = {2'b00, w_d_ep} + {2'b00, w_d_ce} + {2'b00, w_d_ei}
                   + {2'b00, w_d_ea} + {2'b00, w_d_eu};

  logic w_conflict;
  assign w_conflict = (w_drv_cnt > 3'd1);

  logic [7:0] w_bus;
  always_comb begin
    w_bus = 8'h00;
    if (w_drv_cnt == 3'd1) begin
      if (w_d_ep)      w_bus = {4'h0, r_pc};
      else if (w_d_ce) w_bus = r_ram[r_mar];
      else if (w_d_ei) w_bus = {4'h0, r_ir[3:0]};
      else if (w_d_ea) w_bus = r_acc;
      else             w_bus = w_alu;
    end
  end

  logic w_upd;
  assign w_upd = ~prog_en & ~w_conflict;

  // RAM is outside the reset domain so a reset never destroys a loaded program.
  always_ff @(posedge clk) begin
    if (prog_en) r_ram[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= 4'h0;
      r_mar <= 4'h0;
      r_ir  <= 8'h00;
      r_acc <= 8'h00;
      r_b   <= 8'h00;
      r_out <= 8'h00;
    end else if (w_upd) begin
      if (w_lm) r_mar <= w_bus[3:0];
      if (w_li) r_ir  <= w_bus;
      if (w_la) r_acc <= w_bus;
      if (w_lb) r_b   <= w_bus;
      if (w_lo) r_out <= w_bus;
      if (w_cp) r_pc  <= r_pc + 4'd1;
    end
  end

  assign opcode       = r_ir[7:4];
  assign out_reg      = r_out;
  assign wbus         = w_bus;
  assign bus_conflict = w_conflict;

endmodule

// File: tb/tb_sap_datapath.sv
// Randomized and directed bench for sap_datapath; a behavioural model predicts
// bus, conflict, opcode and out_reg for every cycle into a scoreboard queue.
module tb_sap_datapath;

  localparam int W = 22;  // {care, wbus[7:0], conflict, opcode[3:0], out_reg[7:0]}

  localparam logic [11:0] IDLE   = 12'h3E3;
  localparam logic [11:0] RD_PC  = 12'h7E3;
  localparam logic [11:0] RD_ACC = 12'h3F3;
  localparam logic [11:0] RD_MEM = 12'h2E3;
  localparam logic [11:0] RD_IR  = 12'h3A3;
  localparam logic [11:0] RD_SUM = 12'h3E7;
  localparam logic [11:0] LD_B   = 12'h2E1;
  localparam logic [11:0] LD_A   = 12'h2C3;
  localparam logic [11:0] INC_PC = 12'hBE3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] con;
  logic        prog_en;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  out_reg;
  logic [7:0]  wbus;
  logic        bus_conflict;

  sap_datapath dut (
    .clk(clk), .rst(rst), .con(con), .prog_en(prog_en),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .opcode(opcode), .out_reg(out_reg), .wbus(wbus), .bus_conflict(bus_conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  // Machine state as the model sees it.
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_ir, m_acc, m_b, m_out;
  logic [7:0] m_ram [16];

  // Collect every enabled source; one source wins the bus, more than one is a conflict.
  function automatic void model_bus(input logic [11:0] c, input bit pe,
                                    output logic [7:0] bus, output bit conf);
    logic [7:0] src[$];
    if (!pe) begin
      if (c[10])  src.push_back({4'h0, m_pc});
      if (!c[8])  src.push_back(m_ram[m_mar]);
      if (!c[6])  src.push_back({4'h0, m_ir[3:0]});
      if (c[4])   src.push_back(m_acc);
      if (c[2])   src.push_back(c[3] ? (m_acc - m_b) : (m_acc + m_b));
    end
    conf = (src.size() > 1);
    bus  = (src.size() == 1) ? src[0] : 8'h00;
  endfunction

  task automatic step(input logic [11:0] c, input bit r, input bit pe,
                      input logic [3:0] pa, input logic [7:0] pd, input bit care);
    logic [7:0] bus;
    bit conf;
    con = c; rst = r; prog_en = pe; prog_addr = pa; prog_data = pd;
    model_bus(c, pe, bus, conf);
    exp_q.push_back({care, bus, conf, m_ir[7:4], m_out});
    if (r) begin
      m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00; m_acc = 8'h00; m_b = 8'h00; m_out = 8'h00;
    end else if (!pe && !conf) begin
      if (!c[9]) m_mar = bus[3:0];
      if (!c[7]) m_ir  = bus;
      if (!c[5]) m_acc = bus;
      if (!c[1]) m_b   = bus;
      if (!c[0]) m_out = bus;
      if (c[11]) m_pc  = m_pc + 4'd1;
    end
    if (pe) m_ram[pa] = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [11:0] c);
    step(c, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    step(12'($urandom_range(0, 4095)), 1'b0, 1'b1, a, d, 1'b1);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: each negedge consumes exactly one expectation pushed by the driver
  // for the inputs applied after the preceding posedge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[21]) begin
        chk("wbus",         wbus,                 e[20:13]);
        chk("bus_conflict", {7'h0, bus_conflict}, {7'h0, e[12]});
        chk("opcode",       {4'h0, opcode},       {4'h0, e[11:8]});
        chk("out_reg",      out_reg,              e[7:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_pc = 4'h0; m_mar = 4'h0; m_ir = 8'h00; m_acc = 8'h00; m_b = 8'h00; m_out = 8'h00;
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    con = IDLE; rst = 1'b1; prog_en = 1'b0; prog_addr = 4'h0; prog_data = 8'h00;
    @(posedge clk);
    #1;
    step(IDLE, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0);

    // Load the whole RAM with random con applied to prove con is ignored.
    for (int a = 0; a < 16; a++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      if (a == 0) d = 8'h09;
      if (a == 9) d = 8'h1C;
      prog(4'(a), d);
    end
    step(IDLE, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
    run(IDLE);

    // Fetch then LDA 9.
    run(12'h5E3); run(12'hBE3); run(12'h263);
    run(RD_IR); run(RD_PC);
    run(12'h1A3); run(RD_MEM);
    run(12'h2C3); run(RD_ACC);

    // ADD with wrap: ACC=1C, B=F0.
    prog(4'h9, 8'hF0); run(LD_B); run(12'h3C7); run(RD_ACC);

    // SUB going negative, then latch into OUT.
    prog(4'h9, 8'h05); run(LD_A);
    prog(4'h9, 8'h07); run(LD_B);
    run(12'h3CF); run(RD_ACC); run(12'h3F2); run(IDLE);

    // Conflict: PC=3, ACC=AA, then EP+EA together.
    run(INC_PC); run(INC_PC); run(RD_PC);
    prog(4'h9, 8'hAA); run(LD_A);
    run(12'h7D3); run(RD_PC); run(RD_ACC); run(RD_SUM);

    // Driver and load on the same register.
    run(12'hFE3); run(RD_PC);
    run(12'h3D3); run(RD_ACC);
    run(12'h3C7); run(RD_ACC);

    // PC wrap 15 -> 0.
    while (m_pc != 4'hF) run(INC_PC);
    run(RD_PC); run(INC_PC); run(RD_PC);

    // Reset mid-operation, then reset with a RAM write.
    step(LD_A, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1);
    run(RD_PC); run(RD_ACC); run(RD_IR); run(RD_SUM); run(RD_MEM);
    step(IDLE, 1'b1, 1'b1, 4'h0, 8'h3C, 1'b1);
    run(RD_MEM);

    // Random control words with occasional programming and reset.
    for (int i = 0; i < 400; i++) begin
      step(12'($urandom_range(0, 4095)), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: run(RD_PC);
          1: run(RD_ACC);
          2: run(RD_MEM);
          3: run(RD_IR);
          default: run(RD_SUM);
        endcase
      end
    end

    run(IDLE);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain cyc=%0d got=%0d want=0 pending", cyc, exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
